des_pbox: RTL and testbench

- Registered implementation of the DES round-function P permutation, a fixed 32-bit bit shuffle.
- Sits after the S-box substitution stage in each Feistel round of the Triple-DES datapath; its output is XORed with the left half.
- Takes one 32-bit word per cycle and returns the permuted word one clock later with a valid flag.
- Optionally also provides the inverse permutation.

---
 rtl/des_pbox.sv | 70 +++++++
 tb/tb_des_pbox.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/des_pbox.sv
// des_pbox: registered DES round-function P permutation (32-bit fixed bit shuffle).
// Define PBOX_INVERSE_EN to let the inv port select the inverse permutation P^-1.
module des_pbox (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        in_valid,
    input  logic        inv,
    output logic [31:0] p_data,
    output logic        out_valid
);

    // Entry n is the DES source bit (1 = MSB) for output DES bit n+1.
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    logic [31:0] fwd_w;
    logic [31:0] perm_w;
    logic [31:0] p_data_d, p_data_q;
    logic        out_valid_d, out_valid_q;

    for (genvar i = 0; i < 32; i++) begin : g_fwd
        localparam int SRC = 32 - P_TAB[i];
        assign fwd_w[31 - i] = data[SRC];
    end

`ifdef PBOX_INVERSE_EN
    logic [31:0] inv_w;

    // Same wiring run backwards: input bit i lands on output bit P[i].
    for (genvar i = 0; i < 32; i++) begin : g_inv
        localparam int DST = 32 - P_TAB[i];
        assign inv_w[DST] = data[31 - i];
    end

    assign perm_w = inv ? inv_w : fwd_w;
`else
    logic unused_inv;

    assign unused_inv = inv;
    assign perm_w     = fwd_w;
`endif

    // Holding on !in_valid keeps X on an idle data bus out of the register.
    always_comb begin
        p_data_d    = p_data_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_data_d = perm_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_data_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            p_data_q    <= p_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p_data    = p_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_des_pbox.sv
// Self-checking bench for des_pbox: table-driven reference model, per-cycle compare, literal vectors.
module tb_des_pbox;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic        in_valid;
    logic        inv;
    logic [31:0] p_data;
    logic        out_valid;

    int n_cmp = 0;
    int n_err = 0;

    localparam int P_TAB [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

`ifdef PBOX_INVERSE_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    des_pbox dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .in_valid (in_valid),
        .inv      (inv),
        .p_data   (p_data),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic get_bit(logic [31:0] x, int k);
        return x[32 - k];
    endfunction

    // Forward: out bit i = in bit P[i]. Inverse: out bit j = in bit i where P[i] == j.
    function automatic logic [31:0] model(logic [31:0] x, logic use_inv);
        logic [31:0] r;
        r = '0;
        for (int j = 1; j <= 32; j++) begin
            if (!use_inv) begin
                r[32 - j] = get_bit(x, P_TAB[j]);
            end else begin
                for (int i = 1; i <= 32; i++)
                    if (P_TAB[i] == j) r[32 - j] = get_bit(x, i);
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] exp_data;
    logic        exp_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_data  <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= in_valid;
            if (in_valid) exp_data <= model(data, inv & INV_ON);
        end
    end

    always @(negedge clk) begin
        chk("cyc_p_data", p_data, exp_data);
        chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    end

    task automatic send(input logic [31:0] d, input logic iv, input logic vld);
        @(negedge clk);
        data     = d;
        inv      = iv;
        in_valid = vld;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] x, y;

    initial begin
        rst = 1'b1; data = '0; in_valid = 1'b0; inv = 1'b0;

        chk("model_fwd_7fff", model(32'h7FFF_FFFF, 1'b0), 32'hFF7F_FFFF);
        chk("model_fwd_aaaa", model(32'hAAAA_AAAA, 1'b0), 32'h59EA_07C5);
        chk("model_inv_0080", model(32'h0080_0000, 1'b1), 32'h8000_0000);

        repeat (3) @(negedge clk);
        chk("reset_p_data", p_data, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        rst = 1'b0;

        send(32'h7FFF_FFFF, 1'b0, 1'b1); after_edge();
        chk("vec_7fff", p_data, 32'hFF7F_FFFF);
        send(32'h0000_0000, 1'b0, 1'b1); after_edge();
        chk("vec_zero", p_data, 32'h0000_0000);
        chk("vec_zero_valid", {31'b0, out_valid}, 32'h1);
        send(32'hAAAA_AAAA, 1'b0, 1'b1); after_edge();
        chk("vec_aaaa", p_data, 32'h59EA_07C5);
        chk("vec_aaaa_valid", {31'b0, out_valid}, 32'h1);

        for (int c = 0; c < 3; c++) begin
            send(32'hFFFF_FFFF, 1'b0, 1'b0); after_edge();
            chk("hold_p_data", p_data, 32'h59EA_07C5);
            chk("hold_out_valid", {31'b0, out_valid}, 32'h0);
        end

        send(32'h8000_0000, 1'b0, 1'b1); after_edge();
        chk("walk_msb", p_data, 32'h0080_0000);
        for (int k = 0; k < 32; k++) begin
            send(32'h1 << k, 1'b0, 1'b1); after_edge();
            chk("walk_onehot", {26'b0, 6'($countones(p_data))}, 32'h1);
        end

`ifdef PBOX_INVERSE_EN
        send(32'h0080_0000, 1'b1, 1'b1); after_edge();
        chk("inv_0080", p_data, 32'h8000_0000);
        send(32'h59EA_07C5, 1'b1, 1'b1); after_edge();
        chk("inv_59ea", p_data, 32'hAAAA_AAAA);
        for (int r = 0; r < 1000; r++) begin
            x = $urandom;
            send(x, 1'b0, 1'b1); after_edge();
            y = p_data;
            send(y, 1'b1, 1'b1); after_edge();
            chk("roundtrip", p_data, x);
        end
`else
        send(32'h8000_0000, 1'b1, 1'b1); after_edge();
        chk("inv_ignored", p_data, 32'h0080_0000);
`endif

        for (int r = 0; r < 500; r++) begin
            send($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        // Reset between edges while a stream is running.
        send(32'h1234_5678, 1'b0, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_p_data", p_data, 32'h0);
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        for (int c = 0; c < 2; c++) begin
            send($urandom, 1'b0, 1'b1); after_edge();
            chk("rst_hold_p_data", p_data, 32'h0);
            chk("rst_hold_valid", {31'b0, out_valid}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        data = 32'hAAAA_AAAA; inv = 1'b0; in_valid = 1'b1;
        after_edge();
        chk("post_rst_first", p_data, 32'h59EA_07C5);
        chk("post_rst_valid", {31'b0, out_valid}, 32'h1);

        send(32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
